// File: rtl/cplx_pkg.sv
// ---------------------------------------------------------------------------
// cplx_pkg
// Shared definitions for the Jacobi complex datapath.
//   CPLX_W       : packed complex word width (real in [47:24], imag in [23:0])
//   FP_W         : width of one floating-point component
//   MULT_LAT_DEF : default latency of the shared complex multiplier
//   cplx_re/im   : field extraction helpers for a packed complex word
// ---------------------------------------------------------------------------
package cplx_pkg;

    localparam int CPLX_W       = 48;
    localparam int FP_W         = 24;
    localparam int MULT_LAT_DEF = 2;

    function automatic logic [FP_W-1:0] cplx_re(input logic [CPLX_W-1:0] v);
        return v[CPLX_W-1:FP_W];
    endfunction

    function automatic logic [FP_W-1:0] cplx_im(input logic [CPLX_W-1:0] v);
        return v[FP_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection.
//   req    in  NREQ : request vector
//   ptr    in  IDW  : last granted ID; search starts at ptr+1 mod NREQ
//   en     in  1    : when low, no grant is produced
//   gnt    out NREQ : one-hot grant (all-zero if disabled or no request)
//   gnt_id out IDW  : encoded ID of gnt (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic found;
    int   idx;

    // Visit requesters in rotating order ptr+1, ptr+2, ... ptr; first hit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cplx_mult_arbiter.sv
// ---------------------------------------------------------------------------
// cplx_mult_arbiter
// Shares one external pipelined complex multiplier among NREQ requesters.
// One operand pair is issued per cycle, tagged with its requester ID; the tag
// travels down a MULT_LAT+1 deep pipeline so that it lines up with mult_op,
// and the product is returned (registered) to the issuing requester.
//
// Handshake: a requester transfers an operand pair on a rising edge where
// req_valid[i] & req_ready[i]; req_ready is combinational and at most one-hot.
// Responses have no backpressure: rsp_valid[i] is a one-cycle pulse that the
// requester must sink.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   req_valid/a/b     : per-requester operand pairs (48 bits each, packed)
//   req_ready         : one-hot grant
//   hold              : suppresses all grants this cycle
//   mult_a/mult_b     : registered operands to the multiplier
//   mult_op           : multiplier product, MULT_LAT cycles after mult_a/b
//   rsp_valid/data/id : registered response, one-hot valid + ID
//   busy              : any issued operation still in the tag pipeline
// ---------------------------------------------------------------------------
module cplx_mult_arbiter
    import cplx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CPLX_W-1:0] req_a,
    input  logic [NREQ*CPLX_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   hold,
    output logic [CPLX_W-1:0]      mult_a,
    output logic [CPLX_W-1:0]      mult_b,
    input  logic [CPLX_W-1:0]      mult_op,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [CPLX_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    localparam int DEPTH = MULT_LAT + 1;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic              xfer;

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CPLX_W-1:0] mult_a_q, mult_a_d;
    logic [CPLX_W-1:0] mult_b_q, mult_b_d;
    logic [DEPTH-1:0]  tag_vld_q, tag_vld_d;
    logic [IDW-1:0]    tag_id_q [DEPTH];
    logic [IDW-1:0]    tag_id_d [DEPTH];
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [CPLX_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (!hold),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // The arbiter only grants valid requesters, so any grant is a transfer.
    assign xfer = |gnt;

    always_comb begin
        ptr_d       = ptr_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        if (xfer) begin
            ptr_d    = gnt_id;
            mult_a_d = req_a[CPLX_W*int'(gnt_id) +: CPLX_W];
            mult_b_d = req_b[CPLX_W*int'(gnt_id) +: CPLX_W];
        end

        // Stage 0 is loaded at the issue edge; the last stage is valid in the
        // same cycle the matching product sits on mult_op.
        tag_vld_d   = {tag_vld_q[DEPTH-2:0], xfer};
        tag_id_d[0] = gnt_id;
        for (int i = 1; i < DEPTH; i++) begin
            tag_id_d[i] = tag_id_q[i-1];
        end

        if (tag_vld_q[DEPTH-1]) begin
            rsp_valid_d = NREQ'(1) << tag_id_q[DEPTH-1];
            rsp_data_d  = mult_op;
            rsp_id_d    = tag_id_q[DEPTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= IDW'(NREQ - 1);
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign req_ready = gnt;
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_cplx_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cplx_mult_arbiter
// Drives the arbiter with directed and random requests against a stub
// multiplier (MULT_LAT registers of in1 ^ in2). A round-robin reference model
// predicts each grant; each issue pushes {due cycle, id, a^b} onto exp_q and
// a negedge monitor pops and compares whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_cplx_mult_arbiter;
    import cplx_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;
    localparam int QW   = 16 + IDW + CPLX_W;

    // ---------------- clock / reset ----------------
    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*CPLX_W-1:0] req_a = '0;
    logic [NREQ*CPLX_W-1:0] req_b = '0;
    logic                   hold = 1'b0;
    logic [NREQ-1:0]        req_ready;
    logic [CPLX_W-1:0]      mult_a, mult_b, mult_op;
    logic [NREQ-1:0]        rsp_valid;
    logic [CPLX_W-1:0]      rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;

    always #5 clock = ~clock;

    cplx_mult_arbiter #(
        .NREQ     (NREQ),
        .MULT_LAT (LAT),
        .IDW      (IDW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_op   (mult_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Stub multiplier: two registers, product = in1 ^ in2.
    logic [CPLX_W-1:0] stub_s0 = '0;
    logic [CPLX_W-1:0] stub_s1 = '0;
    always @(posedge clock) begin
        stub_s0 <= mult_a ^ mult_b;
        stub_s1 <= stub_s0;
    end
    assign mult_op = stub_s1;

    // ---------------- reference state ----------------
    int                cyc = 0;
    int                last_rst = -1;
    bit                issued [0:8191];
    logic [QW-1:0]     exp_q [$];
    logic [CPLX_W-1:0] exp_ma = '0;
    logic [CPLX_W-1:0] exp_mb = '0;
    logic [CPLX_W-1:0] pend_a = '0;
    logic [CPLX_W-1:0] pend_b = '0;
    bit                pend = 1'b0;
    logic [CPLX_W-1:0] last_data = '0;
    logic [IDW-1:0]    last_id = '0;
    int                m_ptr = NREQ - 1;
    bit                mon_on = 1'b0;
    int                grants [$];
    int                ncmp = 0;
    int                nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: if not held, the first valid requester after ptr wins.
    function automatic int model_grant(input logic [NREQ-1:0] v, input bit h, input int p);
        if (h) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Edge bookkeeping: cycle number, reset flush, operand register model.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            last_rst  = cyc;
            exp_q.delete();
            exp_ma    = '0;
            exp_mb    = '0;
            last_data = '0;
            last_id   = '0;
            m_ptr     = NREQ - 1;
            pend      = 1'b0;
        end else if (pend) begin
            exp_ma = pend_a;
            exp_mb = pend_b;
            pend   = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[CPLX_W*i +: CPLX_W] = {16'($urandom), 32'($urandom)};
            req_b[CPLX_W*i +: CPLX_W] = {16'($urandom), 32'($urandom)};
        end
    endtask

    // One cycle: apply inputs, check the grant, record the issue, cross the edge.
    task automatic step(input logic [NREQ-1:0] v, input bit h, input bit r);
        int                g;
        logic [CPLX_W-1:0] a, b;
        req_valid = v;
        hold      = h;
        reset     = r;
        #3;
        g = r ? -1 : model_grant(v, h, m_ptr);
        if (!r) chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            a = req_a[CPLX_W*g +: CPLX_W];
            b = req_b[CPLX_W*g +: CPLX_W];
            exp_q.push_back({16'(cyc + 4), IDW'(g), a ^ b});
            issued[cyc + 1] = 1'b1;
            pend_a = a;
            pend_b = b;
            pend   = 1'b1;
            m_ptr  = g;
            grants.push_back(g);
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [QW-1:0] m_e;
    bit            m_eb;

    always @(negedge clock) begin
        if (mon_on) begin
            m_eb = 1'b0;
            for (int e = cyc - 2; e <= cyc; e++) begin
                if (e > last_rst && e >= 0 && issued[e]) m_eb = 1'b1;
            end
            chk("busy", 64'(busy), 64'(m_eb));
            chk("mult_a", 64'(mult_a), 64'(exp_ma));
            chk("mult_b", 64'(mult_b), 64'(exp_mb));
            while (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 16]) < cyc) begin
                m_e = exp_q.pop_front();
                ncmp++;
                nfail++;
                $display("FAIL rsp_missing: got none expected id %0d data %0h by cycle %0d",
                         m_e[CPLX_W +: IDW], m_e[CPLX_W-1:0], m_e[QW-1 -: 16]);
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(m_e[QW-1 -: 16]));
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << m_e[CPLX_W +: IDW]);
                    chk("rsp_id", 64'(rsp_id), 64'(m_e[CPLX_W +: IDW]));
                    chk("rsp_data", 64'(rsp_data), 64'(m_e[CPLX_W-1:0]));
                    last_data = m_e[CPLX_W-1:0];
                    last_id   = m_e[CPLX_W +: IDW];
                end
            end else begin
                chk("rsp_hold_data", 64'(rsp_data), 64'(last_data));
                chk("rsp_hold_id", 64'(rsp_id), 64'(last_id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1;
        step('0, 1'b0, 1'b1);
        mon_on = 1'b1;
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Single issue from requester 0: product 1^2 = 3, id 0.
        req_a[47:0] = 48'h1;
        req_b[47:0] = 48'h2;
        grants.delete();
        step(4'b0001, 1'b0, 1'b0);
        chk("single_grant", 64'(grants.size()), 64'd1);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // All valid after reset: strict 0,1,2,3 rotation.
        step('0, 1'b0, 1'b1);
        grants.delete();
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(4'b1111, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) chk("grant_order", 64'(grants[i]), 64'(i % 4));

        // Requesters 1 and 3 with hold for two cycles.
        grants.delete();
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        chk("hold_no_grant", 64'(grants.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(4'b1010, 1'b0, 1'b0);
        end
        chk("hold_g0", 64'(grants[0]), 64'd1);
        chk("hold_g1", 64'(grants[1]), 64'd3);
        chk("hold_g2", 64'(grants[2]), 64'd1);

        // Single active requester 2 granted every cycle.
        grants.delete();
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step(4'b0100, 1'b0, 1'b0);
        end
        chk("solo_count", 64'(grants.size()), 64'd5);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Reset two cycles after the last of three issues flushes them.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(4'b1111, 1'b0, 1'b0);
        end
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        grants.delete();
        rand_ops();
        step(4'b1111, 1'b0, 1'b0);
        chk("post_reset_grant", 64'(grants[0]), 64'd0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Requester 1 valid every other cycle.
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step(4'b0010, 1'b0, 1'b0);
            step('0, 1'b0, 1'b0);
        end

        // Random traffic with random hold and rare resets.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            if ($urandom_range(0, 63) == 0)
                step('0, 1'b0, 1'b1);
            else
                step(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
        end

        for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
